// File: rtl/clock_select_sequencer.sv
// Round-robin switch sequencer for an ungated two-input clock selector: issues one
// SELECT_ENABLE pulse per switch, then tracks the selector's output reset before acknowledging.
module clock_select_sequencer #(
   parameter int NREQ    = 2,
   parameter int HOLDOFF = 4,
   parameter int TIMEOUT = 64
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] REQ,
   input  logic [NREQ-1:0] REQ_SEL,
   output logic [NREQ-1:0] ACK,
   output logic            ERR,
   output logic            SELECT,
   output logic            SELECT_ENABLE,
   input  logic            SEL_RST_N,
   output logic            CUR_SEL,
   output logic            BUSY
);

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CMAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
   localparam int CW   = $clog2(CMAX) + 1;

   localparam logic [IW:0]   NREQ_W       = (IW+1)'(NREQ);
   localparam logic [IW-1:0] LAST_IDX     = IW'(NREQ - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLDOFF - 1);

   typedef enum logic [2:0] {
      IDLE,
      ACK_ST,
      ISSUE,
      WAIT_ASSERT,
      WAIT_RELEASE,
      HOLD
   } state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] grant_reg, grant_next;
   logic [IW-1:0] ptr_reg, ptr_next;
   logic          target_reg, target_next;
   logic          cur_sel_reg, cur_sel_next;
   logic          select_reg, select_next;
   logic          err_reg, err_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          sync1_reg, sync2_reg;
   logic          rst_s;

   assign rst_s = sync2_reg;

   // Rotate requests so bit 0 is the requester at ptr; the first set bit is the grant offset.
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              found;
   logic [IW:0]       offset;
   logic [IW:0]       sum;
   logic [IW-1:0]     pick;

   assign req_dbl = {REQ, REQ};
   assign req_rot = NREQ'(req_dbl >> ptr_reg);

   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_rot[i]) begin
            found  = 1'b1;
            offset = (IW+1)'(i);
         end
      end
      sum = {1'b0, ptr_reg} + offset;
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      pick = sum[IW-1:0];
   end

   always_comb begin
      state_next   = state_reg;
      grant_next   = grant_reg;
      ptr_next     = ptr_reg;
      target_next  = target_reg;
      cur_sel_next = cur_sel_reg;
      select_next  = select_reg;
      err_next     = err_reg;
      cnt_next     = cnt_reg;

      case (state_reg)
         IDLE: begin
            if (found) begin
               grant_next  = pick;
               target_next = REQ_SEL[pick];
               ptr_next    = (pick == LAST_IDX) ? '0 : pick + 1'b1;
               if (REQ_SEL[pick] == cur_sel_reg) begin
                  state_next = ACK_ST;
               end else begin
                  select_next = REQ_SEL[pick];
                  state_next  = ISSUE;
               end
            end
         end
         ISSUE: begin
            cur_sel_next = target_reg;
            cnt_next     = '0;
            state_next   = WAIT_ASSERT;
         end
         WAIT_ASSERT: begin
            if (!rst_s) begin
               cnt_next   = '0;
               state_next = WAIT_RELEASE;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               err_next   = 1'b1;
               state_next = ACK_ST;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (rst_s) begin
               cnt_next   = '0;
               state_next = HOLD;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               err_next   = 1'b1;
               state_next = ACK_ST;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HOLD: begin
            // A reset re-assertion restarts the release wait; the holdoff counts from the final release.
            if (!rst_s) begin
               cnt_next   = '0;
               state_next = WAIT_RELEASE;
            end else if (cnt_reg == HOLD_LAST) begin
               state_next = ACK_ST;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ACK_ST: begin
            err_next   = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= IDLE;
         grant_reg   <= '0;
         ptr_reg     <= '0;
         target_reg  <= 1'b0;
         cur_sel_reg <= 1'b0;
         select_reg  <= 1'b0;
         err_reg     <= 1'b0;
         cnt_reg     <= '0;
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
      end else begin
         state_reg   <= state_next;
         grant_reg   <= grant_next;
         ptr_reg     <= ptr_next;
         target_reg  <= target_next;
         cur_sel_reg <= cur_sel_next;
         select_reg  <= select_next;
         err_reg     <= err_next;
         cnt_reg     <= cnt_next;
         sync1_reg   <= SEL_RST_N;
         sync2_reg   <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ack
         assign ACK[gi] = (state_reg == ACK_ST) && (grant_reg == IW'(gi));
      end
   endgenerate

   assign ERR           = (state_reg == ACK_ST) && err_reg;
   assign SELECT        = select_reg;
   assign SELECT_ENABLE = (state_reg == ISSUE);
   assign CUR_SEL       = cur_sel_reg;
   assign BUSY          = (state_reg != IDLE);

endmodule

// File: doc/clock_select_sequencer.md
# clock_select_sequencer

Sequencing controller for the ungated two-input clock selector. It arbitrates switch requests from up to NREQ requesters round-robin and drives the selector's SELECT/SELECT_ENABLE for exactly one cycle per switch. It then tracks the selector's output reset through assertion and release, plus a holdoff period, before acknowledging the requester. It sits in the control clock domain, the same clock that feeds the selector's CLK.

## Interface
- NREQ, 2: number of requesters (1..8)
- HOLDOFF, 4: cycles after synchronized selector reset release before ACK (>=1)
- TIMEOUT, 64: maximum cycles to wait in each reset-wait state before error (>=2)
- CLK  in  1  single clock for all logic
- RST  in  1  reset, synchronous and active-high
- REQ  in  NREQ  per-requester switch request, level, held until ACK
- REQ_SEL  in  NREQ  per-requester target (1 = A clock, 0 = B clock), valid while REQ high
- ACK  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- ERR  out  1  one-cycle pulse coincident with ACK when the sequence timed out
- SELECT  out  1  to selector SELECT
- SELECT_ENABLE  out  1  to selector SELECT_ENABLE, one-cycle pulse
- SEL_RST_N  in  1  selector output reset (low = new clock in reset), asynchronous to CLK
- CUR_SEL  out  1  last select value issued
- BUSY  out  1  high in every state except IDLE

## Operation
- SEL_RST_N passes through a 2-flop synchronizer before use; rst_s below means the synchronized value.
- States: IDLE, ACK_ST, ISSUE, WAIT_ASSERT, WAIT_RELEASE, HOLD.
- IDLE: if any REQ is high, grant the first requesting index at or after ptr, wrapping modulo NREQ. Register grant index g and target REQ_SEL[g]. Set ptr = g+1 mod NREQ.
  - If target == CUR_SEL, go to ACK_ST (no switch).
  - Otherwise go to ISSUE.
- ISSUE: SELECT_ENABLE=1, SELECT=target for this cycle only. CUR_SEL <= target. Clear the timeout counter. Go to WAIT_ASSERT.
- WAIT_ASSERT: count cycles.
  - rst_s==0: go to WAIT_RELEASE and clear the counter.
  - Counter reaches TIMEOUT-1: set err, go to ACK_ST.
- WAIT_RELEASE: count cycles.
  - rst_s==1: go to HOLD and clear the counter.
  - Timeout: set err, go to ACK_ST.
- HOLD: count HOLDOFF cycles, then go to ACK_ST.
  - If rst_s returns to 0 during HOLD, go back to WAIT_RELEASE and clear the counter.
- ACK_ST: ACK[g]=1 and ERR=err for one cycle. Clear err. Go to IDLE.
- SELECT holds its last driven value outside ISSUE; only SELECT_ENABLE gates its effect.
- Counters are sized $clog2(max(TIMEOUT,HOLDOFF))+1 bits and never wrap.
- REQ dropped by the granted requester mid-sequence: the sequence still completes and ACK still pulses to g.
- New REQ edges while BUSY are ignored until IDLE. Requests are not queued beyond their held level.
- A REQ still high in the cycle after its ACK counts as a new request.

## Timing
- Reset values: state IDLE, ACK=0, ERR=0, SELECT=0, SELECT_ENABLE=0, CUR_SEL=0 (matches selector reset to B), BUSY=0, ptr=0, err=0, synchronizer flops=1.
- RST high mid-sequence: IDLE on the next edge, with all outputs at reset values. No ACK is produced for the aborted grant.
- Same-value request: REQ sampled at edge t, ACK at cycle t+1, back in IDLE at t+2.
- Switch request:
  - REQ sampled at edge t.
  - SELECT_ENABLE high during cycle t+1.
  - rst_s lags SEL_RST_N by 2 cycles.
  - ACK occurs HOLDOFF+1 cycles after the cycle rst_s is first seen high in WAIT_RELEASE.
- Timeout ACK: WAIT_ASSERT timeout gives ACK TIMEOUT+1 cycles after ISSUE.
- SELECT_ENABLE is never high in two consecutive cycles. At most one ACK bit is high in any cycle.

## Test plan
- Reset with REQ=2'b01, REQ_SEL=2'b00 -> ACK=2'b01 one cycle later, SELECT_ENABLE never pulses, CUR_SEL stays 0.
- Requester 0 requests SEL=1; model SEL_RST_N low 3 cycles after SELECT_ENABLE and high 5 cycles later -> one SELECT_ENABLE pulse with SELECT=1; ACK[0] 5 cycles (HOLDOFF+1) after rst_s rises; ERR=0; CUR_SEL=1.
- Both REQ high continuously with alternating targets -> grants alternate 0,1,0,1. Each switch gets exactly one SELECT_ENABLE and the ACKs are one-hot.
- SEL_RST_N held high after ISSUE -> ACK and ERR pulse together 65 cycles after the ISSUE cycle; CUR_SEL still shows the new value.
- SEL_RST_N glitches low for 1 cycle during HOLD -> the state returns to WAIT_RELEASE and ACK is delayed by the full holdoff after the final release.
- RST asserted during WAIT_RELEASE -> next cycle all outputs are 0, BUSY=0, no ACK; a subsequent request is serviced starting from ptr=0.
